// File: rtl/vga_pattern_gen.sv
// Mode-switchable RGB332 test-pattern generator driven by VGA timing counters.
// Six patterns; mode changes only on the frame boundary, and the pixel output is registered.
module vga_pattern_gen #(
    parameter int unsigned HC_W            = 11,
    parameter int unsigned VC_W            = 11,
    parameter int unsigned HBP             = 360,
    parameter int unsigned VBP             = 41,
    parameter int unsigned STRIPE_LOG2     = 4,
    parameter int unsigned BAR_W           = 160,
    parameter logic [7:0]  SOLID_RGB       = 8'b000_111_00,
    parameter int unsigned INIT_MODE       = 0,
    parameter int unsigned FRAMES_PER_MODE = 120,
    parameter int unsigned SCROLL_STEP     = 1
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            vidon,
    input  logic [HC_W-1:0] hc,
    input  logic [VC_W-1:0] vc,
    input  logic            next,
    input  logic            auto,
    output logic [2:0]      red,
    output logic [2:0]      green,
    output logic [1:0]      blue,
    output logic [2:0]      mode
);

    localparam int unsigned BC_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int unsigned FC_W = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;

    localparam logic [HC_W-1:0] HBP_V    = HC_W'(HBP);
    localparam logic [HC_W-1:0] HBP_M1   = HC_W'(HBP - 1);
    localparam logic [VC_W-1:0] VBP_V    = VC_W'(VBP);
    localparam logic [VC_W-1:0] STEP_V   = VC_W'(SCROLL_STEP);
    localparam logic [BC_W-1:0] BAR_LAST = BC_W'(BAR_W - 1);
    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FRAMES_PER_MODE - 1);

    localparam logic [7:0] RGB_RED   = 8'b111_000_00;
    localparam logic [7:0] RGB_GREEN = 8'b000_111_00;

    typedef enum logic [2:0] {
        StSolid   = 3'd0,
        StHstripe = 3'd1,
        StVstripe = 3'd2,
        StChecker = 3'd3,
        StBars    = 3'd4,
        StScroll  = 3'd5
    } mode_e;

    localparam mode_e INIT_ST = mode_e'(3'(INIT_MODE));

    mode_e            mode_q, mode_d;
    logic             pending_q, pending_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [VC_W-1:0]  scroll_q, scroll_d;
    logic [BC_W-1:0]  bar_cnt_q, bar_cnt_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic [7:0]       rgb_q, rgb_d;

    logic             frame_tick;
    logic             auto_hit;
    logic             advance;
    logic [HC_W-1:0]  x;
    logic [VC_W-1:0]  y;
    logic [VC_W-1:0]  y_scr;
    logic [7:0]       hstripe_rgb;
    logic [7:0]       vstripe_rgb;
    logic [7:0]       scroll_rgb;
    logic [7:0]       checker_rgb;
    logic [7:0]       bar_rgb;
    logic             unused_bits;

    assign frame_tick = (hc == '0) && (vc == '0);
    assign auto_hit   = auto && (frame_cnt_q == FC_LAST);
    // A next pulse coincident with the tick counts for that tick.
    assign advance    = frame_tick && (pending_q || next || auto_hit);

    // Mode FSM: state register.
    always_ff @(posedge clk) begin
        if (clr) begin
            mode_q <= INIT_ST;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode FSM: next state.
    always_comb begin
        mode_d = mode_q;
        if (advance) begin
            case (mode_q)
                StSolid:   mode_d = StHstripe;
                StHstripe: mode_d = StVstripe;
                StVstripe: mode_d = StChecker;
                StChecker: mode_d = StBars;
                StBars:    mode_d = StScroll;
                StScroll:  mode_d = StSolid;
                default:   mode_d = StSolid;
            endcase
        end
    end

    // Mode FSM: outputs.
    always_comb begin
        mode = mode_q;
    end

    always_comb begin
        pending_d   = pending_q | next;
        frame_cnt_d = frame_cnt_q;
        if (advance) begin
            pending_d   = 1'b0;
            frame_cnt_d = '0;
        end else if (frame_tick && auto) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    always_comb begin
        scroll_d = frame_tick ? (scroll_q + STEP_V) : scroll_q;
    end

    // Counters are realigned one cycle ahead so they describe x = 0 when hc reaches HBP.
    always_comb begin
        bar_cnt_d = bar_cnt_q + 1'b1;
        bar_idx_d = bar_idx_q;
        if (hc == HBP_M1) begin
            bar_cnt_d = '0;
            bar_idx_d = 3'd0;
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = '0;
            bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
        end
    end

    assign x     = hc - HBP_V;
    assign y     = vc - VBP_V;
    assign y_scr = y + scroll_q;

    assign hstripe_rgb = y[STRIPE_LOG2]     ? RGB_GREEN : RGB_RED;
    assign vstripe_rgb = x[STRIPE_LOG2]     ? RGB_GREEN : RGB_RED;
    assign scroll_rgb  = y_scr[STRIPE_LOG2] ? RGB_GREEN : RGB_RED;
    assign checker_rgb = (x[STRIPE_LOG2] ^ y[STRIPE_LOG2]) ? 8'hFF : 8'h00;

    always_comb begin
        unique case (bar_idx_q)
            3'd0: bar_rgb = 8'hFF;
            3'd1: bar_rgb = 8'hFC;
            3'd2: bar_rgb = 8'h1F;
            3'd3: bar_rgb = 8'h1C;
            3'd4: bar_rgb = 8'hE3;
            3'd5: bar_rgb = 8'hE0;
            3'd6: bar_rgb = 8'h03;
            3'd7: bar_rgb = 8'h00;
        endcase
    end

    always_comb begin
        rgb_d = 8'h00;
        if (vidon) begin
            case (mode_q)
                StSolid:   rgb_d = SOLID_RGB;
                StHstripe: rgb_d = hstripe_rgb;
                StVstripe: rgb_d = vstripe_rgb;
                StChecker: rgb_d = checker_rgb;
                StBars:    rgb_d = bar_rgb;
                StScroll:  rgb_d = scroll_rgb;
                default:   rgb_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pending_q   <= 1'b0;
            frame_cnt_q <= '0;
            scroll_q    <= '0;
            bar_cnt_q   <= '0;
            bar_idx_q   <= 3'd0;
            rgb_q       <= 8'h00;
        end else begin
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            scroll_q    <= scroll_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            rgb_q       <= rgb_d;
        end
    end

    assign red   = rgb_q[7:5];
    assign green = rgb_q[4:2];
    assign blue  = rgb_q[1:0];

    // Only the stripe-select bit of each coordinate feeds the patterns.
    assign unused_bits = ^{x, y, y_scr};

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised, mode-switchable test-pattern generator for the VGA pipeline, replacing the fixed single-colour stripe block. It sits between the VGA timing generator (which supplies `hc`, `vc` and `vidon`) and the RGB332 output pins. It provides six patterns, including frame-synchronous mode switching, automatic mode cycling and a vertically scrolling stripe pattern. All pixel outputs are registered.

## Interface
- `HC_W`, 11: width of `hc`.
- `VC_W`, 11: width of `vc`.
- `HBP`, 360: value of `hc` at the first active pixel (x = hc − HBP).
- `VBP`, 41: value of `vc` at the first active line (y = vc − VBP).
- `STRIPE_LOG2`, 4: stripe and checker cell size is 2^STRIPE_LOG2 pixels.
- `BAR_W`, 160: colour-bar width in pixels, with 8 bars.
- `SOLID_RGB`, 8'b000_111_00: RGB332 value for SOLID mode.
- `INIT_MODE`, 0: mode loaded at reset, range 0..5.
- `FRAMES_PER_MODE`, 120: frames per mode when auto-cycling, ≥ 1.
- `SCROLL_STEP`, 1: lines added to the scroll offset per frame.

Ports:
- `clk`, in, 1: pixel clock; `hc` advances once per `clk`.
- `clr`, in, 1: synchronous active-high reset.
- `vidon`, in, 1: active-video flag from the timing generator.
- `hc`, in, HC_W: horizontal counter.
- `vc`, in, VC_W: vertical counter.
- `next`, in, 1: single-cycle request to advance the mode, already debounced.
- `auto`, in, 1: 1 enables automatic mode cycling.
- `red`, out, 3: registered red.
- `green`, out, 3: registered green.
- `blue`, out, 2: registered blue.
- `mode`, out, 3: current pattern mode.

## Operation
- **Frame tick.** `frame_tick` is an internal 1-cycle strobe, high in any cycle where `hc == 0` and `vc == 0`.
- **Modes:**
  - 0 SOLID: `SOLID_RGB`.
  - 1 HSTRIPE: red 3'b111 when y[STRIPE_LOG2] = 0, otherwise green 3'b111.
  - 2 VSTRIPE: same rule on x[STRIPE_LOG2].
  - 3 CHECKER: x[STRIPE_LOG2] ^ y[STRIPE_LOG2]; 1 gives 8'hFF, 0 gives 8'h00.
  - 4 BARS: `bar_idx` 0..7 selects white FF, yellow FC, cyan 1F, green 1C, magenta E3, red E0, blue 03, black 00.
  - 5 SCROLL: HSTRIPE rule applied to (y + `scroll_off`) mod 2^VC_W.
- **Bar tracking.** `bar_cnt` is a counter of width ⌈log2 BAR_W⌉; `bar_idx` is 3 bits.
  - Both load 0 in the cycle where `hc == HBP−1`, so they describe pixel x = 0 on the next cycle.
  - Otherwise `bar_cnt` increments each cycle. When `bar_cnt == BAR_W−1` it wraps to 0 and `bar_idx` increments, saturating at 7.
- **Mode register (FSM).**
  - States 0..5. The successor of 5 is 0.
  - A `next` pulse sets a `pending` flag; a mode change never happens mid-frame.
  - On `frame_tick`, advance exactly once if `pending` is set, or if `auto` = 1 and `frame_cnt == FRAMES_PER_MODE−1`. Both conditions together still give a single advance.
  - On every advance, `pending` clears and `frame_cnt` is set to 0.
  - On a non-advancing `frame_tick`, `frame_cnt` increments when `auto` = 1 and holds at its value when `auto` = 0.
  - A `next` pulse arriving in the same cycle as `frame_tick` is taken into account by that tick.
- **Scroll offset.** `scroll_off` (VC_W bits) adds `SCROLL_STEP` on every `frame_tick` in all modes, wrapping modulo 2^VC_W.
- **Blanking.** When `vidon` = 0, the registered RGB output is 0.
- **Arithmetic.** x and y are unsigned HC_W/VC_W subtractions. They are used only while `vidon` = 1, and no range checks are applied.

## Timing
- **Reset.** `clr` sampled high sets:
  - `red` / `green` / `blue` = 0;
  - `mode` = `INIT_MODE`;
  - `pending` = 0, `frame_cnt` = 0, `scroll_off` = 0;
  - `bar_cnt` = 0, `bar_idx` = 0.
  
  Reset wins over every other input in the same cycle. Reset in mid-frame blanks the output from the next cycle onward.
- **Latency.** RGB has 1 `clk` of latency: the output in cycle n+1 reflects `vidon`, `hc`, `vc`, `mode` and `scroll_off` as sampled in cycle n.
- **Mode update.**
  - The new `mode` is visible in the cycle after `frame_tick`.
  - The first pixel rendered in the new mode is the first active pixel of that frame.
  - `mode` changes at most once per frame.
- **Next pulses.** Any number of `next` pulses within one frame produce a single advance.

## Test plan
- **Reset and blanking.** Assert `clr` for 2 cycles with `vidon` = 1 → RGB = 0 and `mode` = `INIT_MODE` on the cycle after; with `vidon` = 0 at any later time → RGB = 0 one cycle later.
- **HSTRIPE.** Mode 1, `hc` = HBP, `vc` = VBP+15, then `vc` = VBP+16 → output {7,0,0} and then {0,7,0}, each 1 cycle after its input.
- **BARS.** Sweep a full line in mode 4 → output FF for x = 0..159, FC starting at x = 160, 00 for x ≥ 1120; bars restart at FF on the next line.
- **Next request.** Pulse `next` 3 times mid-frame → `mode` unchanged until `frame_tick`, then +1 only. A `next` pulse at mode 5 → mode 0.
- **Auto-cycle.** `auto` = 1, `FRAMES_PER_MODE` = 2 → `mode` advances on every 2nd `frame_tick`. With `next` and the auto condition on the same tick → single advance.
- **SCROLL.** Mode 5, after 16 frame ticks with `SCROLL_STEP` = 1 → stripe colours at y = 0 are inverted relative to frame 0. `scroll_off` wraps from 2047 to 0.
